// File: rtl/morse_pkg.sv
// morse_pkg: FSM state encoding, A..H letter table and Morse unit lengths
// shared by the scheduler and its letter queue.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ON,
        GAP,
        LGAP
    } state_t;

    typedef struct packed {
        logic [2:0] cnt;
        logic [3:0] pat;
    } letter_t;

    localparam int DOT_U  = 1;
    localparam int DASH_U = 3;
    localparam int EGAP_U = 1;
    localparam int LGAP_U = 3;
    localparam int WGAP_U = 7;

    // Pattern is MSB-first, 1 = dash, left-aligned in 4 bits.
    function automatic letter_t letter_info(input logic [2:0] code);
        letter_t l;
        unique case (code)
            3'd0:    l = '{cnt: 3'd2, pat: 4'b0100};
            3'd1:    l = '{cnt: 3'd4, pat: 4'b1000};
            3'd2:    l = '{cnt: 3'd4, pat: 4'b1010};
            3'd3:    l = '{cnt: 3'd3, pat: 4'b1000};
            3'd4:    l = '{cnt: 3'd1, pat: 4'b0000};
            3'd5:    l = '{cnt: 3'd4, pat: 4'b0010};
            3'd6:    l = '{cnt: 3'd3, pat: 4'b1100};
            default: l = '{cnt: 3'd4, pat: 4'b0000};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/morse_letter_fifo.sv
// morse_letter_fifo: power-of-two letter queue with a registered
// occupancy count of 0..FIFO_DEPTH; pointers wrap naturally.
module morse_letter_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = 3
) (
    input  logic                         Clk,
    input  logic                         Clr,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DW-1:0]                data_i,
    output logic [DW-1:0]                data_o,
    output logic [$clog2(FIFO_DEPTH):0]  count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;

    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/morse_msg_scheduler.sv
// morse_msg_scheduler: queues A..H letter codes and keys them out as Morse.
// Define MORSE_WORD_GAP_EN to add in_eow and a 7-unit word gap per letter.
module morse_msg_scheduler
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       in_valid,
    input  logic [2:0] in_code,
`ifdef MORSE_WORD_GAP_EN
    input  logic       in_eow,
`endif
    output logic       in_ready,
    output logic       O,
    output logic       busy,
    output logic       letter_done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] UC_M1  = 8'(UNIT_CYCLES - 1);
    localparam logic [2:0] U_DOT  = 3'(DOT_U);
    localparam logic [2:0] U_DASH = 3'(DASH_U);
    localparam logic [2:0] U_EGAP = 3'(EGAP_U);
    localparam logic [2:0] U_LGAP = 3'(LGAP_U - EGAP_U);
`ifdef MORSE_WORD_GAP_EN
    localparam int DW = 4;
    localparam logic [2:0] U_WGAP = 3'(WGAP_U - EGAP_U);
`else
    localparam int DW = 3;
`endif

    logic [DW-1:0] fifo_din, fifo_dout;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;

    state_t        state_q, state_d;
    logic [7:0]    cyc_q, cyc_d;
    logic [2:0]    units_q, units_d;
    logic [2:0]    pat_q, pat_d;
    logic [2:0]    elems_q, elems_d;
    logic          O_q, done_q, done_d;
    logic          unit_end, last;
    logic [2:0]    gap_units;
    letter_t       info;

`ifdef MORSE_WORD_GAP_EN
    logic eow_q, eow_d;
    assign fifo_din  = {in_eow, in_code};
    assign gap_units = eow_q ? U_WGAP : U_LGAP;
`else
    assign fifo_din  = in_code;
    assign gap_units = U_LGAP;
`endif

    assign in_ready    = (count < CW'(FIFO_DEPTH));
    assign push        = in_valid && !full;
    assign busy        = (state_q != IDLE) || !empty;
    assign O           = O_q;
    assign letter_done = done_q;
    assign unit_end    = (cyc_q == UC_M1);
    assign last        = unit_end && (units_q == 3'd1);

    morse_letter_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .DW        (DW)
    ) u_fifo (
        .Clk    (Clk),
        .Clr    (Clr),
        .push_i (push),
        .pop_i  (pop),
        .data_i (fifo_din),
        .data_o (fifo_dout),
        .count_o(count),
        .full_o (full),
        .empty_o(empty)
    );

    always_comb begin
        info    = letter_info(fifo_dout[2:0]);
        state_d = state_q;
        cyc_d   = cyc_q;
        units_d = units_q;
        pat_d   = pat_q;
        elems_d = elems_q;
        pop     = 1'b0;
`ifdef MORSE_WORD_GAP_EN
        eow_d   = eow_q;
`endif
        // Timed states step a cycle counter within a unit, then a unit count.
        if (state_q inside {ON, GAP, LGAP}) begin
            cyc_d   = unit_end ? 8'd0 : cyc_q + 8'd1;
            units_d = unit_end ? units_q - 3'd1 : units_q;
        end
        unique case (state_q)
            IDLE: if (!empty) state_d = LOAD;
            LOAD: begin
                pop     = 1'b1;
                pat_d   = info.pat[2:0];
                elems_d = info.cnt;
                cyc_d   = 8'd0;
                units_d = info.pat[3] ? U_DASH : U_DOT;
                state_d = ON;
`ifdef MORSE_WORD_GAP_EN
                eow_d   = fifo_dout[3];
`endif
            end
            ON: if (last) begin
                state_d = GAP;
                units_d = U_EGAP;
            end
            GAP: if (last) begin
                if (elems_q > 3'd1) begin
                    state_d = ON;
                    pat_d   = {pat_q[1:0], 1'b0};
                    elems_d = elems_q - 3'd1;
                    units_d = pat_q[2] ? U_DASH : U_DOT;
                end else begin
                    state_d = LGAP;
                    units_d = gap_units;
                end
            end
            LGAP: if (last) state_d = empty ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == LGAP) && (cyc_d == UC_M1) && (units_d == 3'd1);
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            units_q <= '0;
            pat_q   <= '0;
            elems_q <= '0;
            O_q     <= 1'b0;
            done_q  <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
            eow_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            units_q <= units_d;
            pat_q   <= pat_d;
            elems_q <= elems_d;
            O_q     <= (state_d == ON);
            done_q  <= done_d;
`ifdef MORSE_WORD_GAP_EN
            eow_q   <= eow_d;
`endif
        end
    end

endmodule

// File: tb/tb_morse_msg_scheduler.sv
// tb_morse_msg_scheduler: directed checks of keying, queueing and reset
// for morse_msg_scheduler at UNIT_CYCLES=4.
module tb_morse_msg_scheduler;

    logic       Clk;
    logic       Clr;
    logic       in_valid;
    logic [2:0] in_code;
`ifdef MORSE_WORD_GAP_EN
    logic       in_eow;
`endif
    logic       in_ready, O, busy, letter_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic o_tr [1024];
    logic d_tr [1024];
    int   idx = 0;
    logic rec = 1'b0;

    morse_msg_scheduler #(
        .UNIT_CYCLES(4),
        .FIFO_DEPTH (4)
    ) dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .in_valid   (in_valid),
        .in_code    (in_code),
`ifdef MORSE_WORD_GAP_EN
        .in_eow     (in_eow),
`endif
        .in_ready   (in_ready),
        .O          (O),
        .busy       (busy),
        .letter_done(letter_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (rec && idx < 1024) begin
            o_tr[idx] = O;
            d_tr[idx] = letter_done;
            idx++;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] code);
        in_valid = 1'b1;
        in_code  = code;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_rec();
        idx = 0;
        rec = 1'b1;
    endtask

    // pat: '.'/'-' per element, '|' letter boundary, '/' word boundary.
    task automatic analyze(input string tag, input string pat, input int nl);
        int unsigned exp_q[$];
        int unsigned got[$];
        int first, lasth, lastd, nd, run, n;
        byte c, nx;
        rec = 1'b0;
        for (int i = 0; i < pat.len(); i++) begin
            c = pat[i];
            if (c == "." || c == "-") begin
                exp_q.push_back(c == "." ? 4 : 12);
                if (i + 1 < pat.len()) begin
                    nx = pat[i+1];
                    exp_q.push_back(nx == "|" ? 13 : (nx == "/" ? 29 : 4));
                end
            end
        end
        first = -1; lasth = -1; lastd = -1; nd = 0;
        for (int i = 0; i < idx; i++) begin
            if (o_tr[i] === 1'b1) begin
                if (first < 0) first = i;
                lasth = i;
            end
            if (d_tr[i] === 1'b1) begin
                nd++;
                lastd = i;
            end
        end
        if (first >= 0) begin
            run = 1;
            for (int i = first + 1; i <= lasth; i++) begin
                if (o_tr[i] === o_tr[i-1]) run++;
                else begin
                    got.push_back(run);
                    run = 1;
                end
            end
            got.push_back(run);
        end
        check({tag, "_nruns"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            check($sformatf("%s_run%0d", tag, k), got[k], exp_q[k]);
        check({tag, "_ndone"}, nd, nl);
        if (nd > 0 && first >= 0)
            check({tag, "_trail"}, lastd - lasth, 12);
    endtask

    initial begin
        Clr      = 1'b1;
        in_valid = 1'b0;
        in_code  = 3'd0;
`ifdef MORSE_WORD_GAP_EN
        in_eow   = 1'b0;
`endif
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_O", O, 0);
        check("rst_done", letter_done, 0);
        ticks(2);
        Clr = 1'b0;
        ticks(2);

        // E: latency, one dot, 12 low cycles, single done, then idle
        start_rec();
        push(3'd4);
        check("e_busy", busy, 1);
        check("e_lat0", O, 0);
        tick();
        check("e_lat1", O, 0);
        tick();
        check("e_lat2", O, 1);
        ticks(40);
        analyze("e", ".", 1);
        check("e_idle", busy, 0);

        // A: dot, gap, dash
        start_rec();
        push(3'd0);
        ticks(50);
        analyze("a", ".-", 1);

        // H then four back-to-back; a fifth is refused while full
        start_rec();
        push(3'd7);
        push(3'd0);
        push(3'd6);
        push(3'd4);
        push(3'd1);
        check("full_ready", in_ready, 0);
        in_valid = 1'b1;
        in_code  = 3'd2;
        tick();
        in_valid = 1'b0;
        check("full_ready2", in_ready, 0);
        ticks(300);
        analyze("q", "....|.-|--.|.|-...", 5);
        check("q_idle", busy, 0);

        // Clr during G's first dash drops it and the queued letters
        push(3'd6);
        push(3'd3);
        push(3'd4);
        for (int k = 0; k < 20 && O !== 1'b1; k++) tick();
        ticks(5);
        check("g_dash", O, 1);
        Clr = 1'b1;
        #1;
        check("clr_O", O, 0);
        check("clr_busy", busy, 0);
        check("clr_ready", in_ready, 1);
        ticks(2);
        Clr = 1'b0;
        start_rec();
        ticks(80);
        analyze("clr", "", 0);
        check("clr_idle", busy, 0);

        // F then C with no idle gap: 13 low cycles between letters
        start_rec();
        push(3'd5);
        push(3'd2);
        ticks(150);
        analyze("fc", "..-.|-.-.", 2);

`ifdef MORSE_WORD_GAP_EN
        // E marked end-of-word, then E: 28 + 1 low cycles between dots
        start_rec();
        in_eow = 1'b1;
        push(3'd4);
        in_eow = 1'b0;
        push(3'd4);
        ticks(80);
        analyze("wg", "./.", 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
